pwm_fader: RTL and testbench

LED brightness stage that sits directly downstream of the button-driven 8-bit level counter. It converts the requested level into a PWM waveform with period-aligned duty updates. An optional slew limiter fades the active duty toward the requested level one step at a time. `pwm_o` is fanned out to the board LEDs; `duty_o` and `at_target` are exported for debug display.

---
 rtl/pwm_fader_if.sv | 19 +
 rtl/pwm_fader.sv | 84 ++++++++
 tb/tb_pwm_fader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_fader_if.sv
// Level request in, PWM waveform and debug status out, for the pwm_fader LED stage.
interface pwm_fader_if;
  logic [7:0] level_i;
  logic       ramp_en;
  logic       pwm_o;
  logic [7:0] duty_o;
  logic       period_start;
  logic       at_target;

  modport master (
    output level_i, ramp_en,
    input  pwm_o, duty_o, period_start, at_target
  );

  modport slave (
    input  level_i, ramp_en,
    output pwm_o, duty_o, period_start, at_target
  );
endinterface

// File: rtl/pwm_fader.sv
// 8-bit PWM generator with period-aligned duty updates, glitch-rejecting level
// capture and an optional one-step-per-N-periods slew limiter.
module pwm_fader #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned RAMP_PERIODS = 4
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  pwm_fader_if.slave  bus
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned RC_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(RAMP_PERIODS - 1);

  logic [PS_W-1:0] r_presc;
  logic [7:0]      r_phase;
  logic [RC_W-1:0] r_ramp_cnt;
  logic [7:0]      r_s1;
  logic [7:0]      r_s2;
  logic [7:0]      r_target;
  logic [7:0]      r_duty;
  logic            r_period_start;

  logic            w_tick;
  logic            w_boundary;
  logic [7:0]      w_target_nxt;
  logic [7:0]      w_duty_nxt;

  assign w_tick     = (r_presc == PS_MAX);
  assign w_boundary = w_tick && (r_phase == 8'hFF);

  // Values loaded into target/duty when the current period ends.
  always_comb begin
    w_target_nxt = r_target;
    w_duty_nxt   = r_duty;
    if (r_s1 == r_s2) begin
      w_target_nxt = r_s2;
    end
    if (!bus.ramp_en) begin
      w_duty_nxt = w_target_nxt;
    end else if (r_ramp_cnt == RC_MAX) begin
      if (r_duty < w_target_nxt) begin
        w_duty_nxt = r_duty + 8'd1;
      end else if (r_duty > w_target_nxt) begin
        w_duty_nxt = r_duty - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_presc        <= '0;
      r_phase        <= 8'd0;
      r_ramp_cnt     <= '0;
      r_s1           <= 8'd0;
      r_s2           <= 8'd0;
      r_target       <= 8'd0;
      r_duty         <= 8'd0;
      r_period_start <= 1'b0;
    end else begin
      r_s1           <= bus.level_i;
      r_s2           <= r_s1;
      r_presc        <= w_tick ? '0 : r_presc + 1'b1;
      r_period_start <= w_boundary;
      if (w_tick) begin
        r_phase <= r_phase + 8'd1;
      end
      if (w_boundary) begin
        r_target   <= w_target_nxt;
        r_duty     <= w_duty_nxt;
        r_ramp_cnt <= (r_ramp_cnt == RC_MAX) ? '0 : r_ramp_cnt + 1'b1;
      end
    end
  end

  // Register-only compares keep the LED drive glitch-free and reset-safe.
  assign bus.pwm_o        = (r_phase < r_duty);
  assign bus.duty_o       = r_duty;
  assign bus.period_start = r_period_start;
  assign bus.at_target    = (r_duty == r_target);

endmodule

// File: tb/tb_pwm_fader.sv
// Self-checking bench for pwm_fader: cycle-accurate reference model plus
// table-driven period measurements and hand-written ramp/reset sequences.
module tb_pwm_fader;
  localparam int unsigned P   = 4;
  localparam int unsigned R   = 4;
  localparam int unsigned PER = P * 256;

  logic clk_25mhz;
  logic rst_n;

  pwm_fader_if bus ();

  pwm_fader #(.PRESCALE(P), .RAMP_PERIODS(R)) dut (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  initial clk_25mhz = 1'b0;
  always #20 clk_25mhz = ~clk_25mhz;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Reference model: clocks since release, boundary count, level history.
  int unsigned m_n, m_nb;
  logic [7:0]  m_h1, m_h2, m_target, m_duty;

  typedef struct {
    logic [7:0]  level;
    int unsigned exp_hi;
  } vec_t;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  task model_reset();
    m_n = 0; m_nb = 0; m_h1 = 8'd0; m_h2 = 8'd0; m_target = 8'd0; m_duty = 8'd0;
  endtask

  task model_edge(input logic [7:0] lvl, input logic ren);
    m_n++;
    if (m_n % PER == 0) begin
      m_nb++;
      if (m_h1 == m_h2) m_target = m_h1;
      if (!ren) m_duty = m_target;
      else if (m_nb % R == 0) begin
        if (m_duty < m_target) m_duty = m_duty + 8'd1;
        else if (m_duty > m_target) m_duty = m_duty - 8'd1;
      end
    end
    m_h2 = m_h1;
    m_h1 = lvl;
  endtask

  function automatic int unsigned exp_vec();
    int unsigned phase;
    logic pwm, ps, at;
    phase = (m_n / P) % 256;
    pwm   = (phase < int'(m_duty));
    ps    = (m_n > 0) && (m_n % PER == 0);
    at    = (m_duty == m_target);
    return {21'd0, pwm, ps, at, m_duty};
  endfunction

  function automatic int unsigned act_vec();
    return {21'd0, bus.pwm_o, bus.period_start, bus.at_target, bus.duty_o};
  endfunction

  task automatic cyc();
    logic [7:0] lvl;
    logic ren;
    lvl = bus.level_i;
    ren = bus.ramp_en;
    @(posedge clk_25mhz);
    model_edge(lvl, ren);
    #1;
    check("model{pwm,ps,at,duty}", act_vec(), exp_vec());
  endtask

  task automatic run_to_ps();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2 * PER && !seen; i++) begin
      cyc();
      if (bus.period_start) seen = 1'b1;
    end
    if (!seen) check("period_start_timeout", 0, 1);
  endtask

  // Called in a period_start clock; ends in the next period_start clock.
  task automatic measure(input string name, input int unsigned exp_hi);
    int unsigned hi, extra;
    hi = int'(bus.pwm_o);
    extra = 0;
    for (int i = 1; i < PER; i++) begin
      cyc();
      hi += int'(bus.pwm_o);
      extra += int'(bus.period_start);
    end
    cyc();
    check({name, "_hi_clocks"}, hi, exp_hi);
    check({name, "_ps_inside_period"}, extra, 0);
    check({name, "_ps_after_1024"}, int'(bus.period_start), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk_25mhz);
    @(posedge clk_25mhz);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic align_ramp();
    for (int i = 0; i < R + 1 && (m_nb % R) != 0; i++) run_to_ps();
  endtask

  vec_t vecs[5];
  int unsigned cnt, steps, last_dn, max_duty;
  logic [7:0] prev;
  bit done;

  initial begin
    vecs[0] = '{level: 8'd64,  exp_hi: 256};
    vecs[1] = '{level: 8'd0,   exp_hi: 0};
    vecs[2] = '{level: 8'd255, exp_hi: 1020};
    vecs[3] = '{level: 8'd0,   exp_hi: 0};
    vecs[4] = '{level: 8'd128, exp_hi: 512};

    rst_n = 1'b0;
    bus.level_i = 8'd0;
    bus.ramp_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_25mhz);
    #1;
    check("reset_vec", act_vec(), 32'h100);

    // Asynchronous reset mid-period at duty 128, then restart latency.
    #1 rst_n = 1'b1;
    bus.level_i = 8'd128;
    run_to_ps();
    check("pre_reset_duty", bus.duty_o, 128);
    repeat (400) cyc();
    check("pre_reset_pwm", bus.pwm_o, 1);
    #5 rst_n = 1'b0;
    #1;
    check("async_reset_vec", act_vec(), 32'h100);
    @(posedge clk_25mhz);
    @(posedge clk_25mhz);
    #1 rst_n = 1'b1;
    model_reset();
    cnt = 0;
    done = 1'b0;
    for (int i = 0; i < 2 * PER && !done; i++) begin
      cyc();
      cnt++;
      if (bus.period_start) done = 1'b1;
    end
    check("first_ps_latency", cnt, PER);

    // Direct-level table: level set right after period_start applies next period.
    for (int v = 0; v < 5; v++) begin
      bus.level_i = vecs[v].level;
      run_to_ps();
      check("tbl_duty", bus.duty_o, vecs[v].level);
      check("tbl_at_target", bus.at_target, 1);
      measure("tbl", vecs[v].exp_hi);
    end

    // One-clock glitch to 99 straddling a boundary is rejected.
    bus.level_i = 8'd4;
    run_to_ps();
    run_to_ps();
    repeat (PER - 2) cyc();
    bus.level_i = 8'd99;
    cyc();
    bus.level_i = 8'd4;
    cyc();
    check("glitch_ps", bus.period_start, 1);
    check("glitch_duty", bus.duty_o, 4);
    check("glitch_at_target", bus.at_target, 1);
    run_to_ps();
    check("glitch_duty_next", bus.duty_o, 4);

    // Ramp 0 -> 10 from reset.
    bus.level_i = 8'd10;
    bus.ramp_en = 1'b1;
    do_reset();
    steps = 0; last_dn = 0; prev = 8'd0; max_duty = 0; done = 1'b0;
    for (int i = 0; i < 12 * R * PER && !done; i++) begin
      cyc();
      if (bus.duty_o != prev) begin
        steps++;
        check("ramp_step_up", bus.duty_o, prev + 8'd1);
        check("ramp_spacing", m_n - last_dn, R * PER);
        check("ramp_at_target", bus.at_target, (bus.duty_o == 8'd10));
        last_dn = m_n;
        prev = bus.duty_o;
        if (bus.duty_o == 8'd10) done = 1'b1;
      end
    end
    check("ramp_steps", steps, 10);
    for (int i = 0; i < (R + 1) * PER; i++) begin
      cyc();
      if (bus.duty_o > max_duty) max_duty = bus.duty_o;
    end
    check("ramp_no_overshoot", max_duty, 10);

    // Reversal: ramping toward 200 at duty 5, request 0 -> next step is 4.
    bus.ramp_en = 1'b0;
    bus.level_i = 8'd5;
    run_to_ps();
    run_to_ps();
    align_ramp();
    check("rev_start_duty", bus.duty_o, 5);
    bus.ramp_en = 1'b1;
    bus.level_i = 8'd200;
    run_to_ps();
    check("rev_hold_duty", bus.duty_o, 5);
    check("rev_at_target", bus.at_target, 0);
    bus.level_i = 8'd0;
    done = 1'b0;
    for (int i = 0; i < (R + 1) * PER && !done; i++) begin
      cyc();
      if (bus.duty_o != 8'd5) done = 1'b1;
    end
    check("rev_step_duty", bus.duty_o, 4);

    // Ramp abort: clearing ramp_en jumps to target at the next boundary.
    bus.ramp_en = 1'b0;
    bus.level_i = 8'd20;
    run_to_ps();
    run_to_ps();
    align_ramp();
    bus.ramp_en = 1'b1;
    bus.level_i = 8'd150;
    run_to_ps();
    check("abort_ramp_duty", bus.duty_o, 20);
    bus.ramp_en = 1'b0;
    run_to_ps();
    check("abort_duty", bus.duty_o, 150);
    check("abort_at_target", bus.at_target, 1);

    // Randomized segments against the model, including very short holds.
    for (int s = 0; s < 14; s++) begin
      bus.level_i = 8'($urandom_range(0, 255));
      bus.ramp_en = 1'($urandom_range(0, 1));
      cnt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(50, 600);
      repeat (cnt) cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
